// File: rtl/interface_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 ultrasonic ranging interface.
package interface_hcsr04_pkg;

  // Default timing at a 50 MHz system clock
  localparam int unsigned DEF_TRIGGER_CYCLES  = 500;
  localparam int unsigned DEF_CM_CYCLES       = 2941;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1_500_000;
  localparam int unsigned DEF_ECHO_MAX_CYCLES = 2_500_000;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned BCD_W   = 12;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_PREPARA     = 4'd1,
    ST_TRIGGER     = 4'd2,
    ST_ESPERA_ECHO = 4'd3,
    ST_MEDE        = 4'd4,
    ST_ARMAZENA    = 4'd5,
    ST_FIM         = 4'd6,
    ST_ERRO        = 4'd7
  } state_t;

  // Three-digit BCD increment that sticks at 999
  function automatic logic [BCD_W-1:0] bcd3_inc(input logic [BCD_W-1:0] v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    logic [BCD_W-1:0] r;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (v == 12'h999)    r = v;
    else if (u != 4'd9)  r = {h, t, u + 4'd1};
    else if (t != 4'd9)  r = {h, t + 4'd1, 4'd0};
    else                 r = {h + 4'd1, 8'h00};
    return r;
  endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// Saturating three-digit BCD counter with synchronous clear.
module contador_bcd_3dig
  import interface_hcsr04_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [BCD_W-1:0] count
);

  // Clear has priority over counting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= bcd3_inc(count);
  end

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 ranging controller: trigger pulse, echo timing, distance in BCD centimetres.
module interface_hcsr04
  import interface_hcsr04_pkg::*;
#(
  parameter int unsigned TRIGGER_CYCLES  = DEF_TRIGGER_CYCLES,
  parameter int unsigned CM_CYCLES       = DEF_CM_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ECHO_MAX_CYCLES = DEF_ECHO_MAX_CYCLES
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               medir,
  input  logic               echo,
  output logic               trigger,
  output logic [BCD_W-1:0]   medida,
  output logic               pronto,
  output logic               erro,
  output logic [STATE_W-1:0] db_estado
);

  localparam int unsigned MAX_TC  = (TRIGGER_CYCLES > CM_CYCLES) ? TRIGGER_CYCLES : CM_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_TC > TIMEOUT_CYCLES) ? MAX_TC : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned ECHO_W  = $clog2(ECHO_MAX_CYCLES + 1);

  state_t             state;
  logic               echo_meta;
  logic               echo_sync;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [ECHO_W-1:0]  echo_cnt;
  logic [BCD_W-1:0]   bcd_count;
  logic               bcd_clear_c;
  logic               bcd_en_c;
  logic               wrap_c;

  // Two-flop synchronizer for the asynchronous echo pin
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_meta <= 1'b0;
      echo_sync <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // Centimetre tick: a full CM_CYCLES period of echo-high time has elapsed
  always_comb begin
    wrap_c      = (cycle_cnt == CNT_W'(CM_CYCLES - 1));
    bcd_clear_c = (state == ST_PREPARA);
    bcd_en_c    = 1'b0;
    if (state == ST_MEDE && echo_sync)
      bcd_en_c = wrap_c;
    else if (state == ST_ESPERA_ECHO && echo_sync)
      bcd_en_c = (CM_CYCLES == 1);
  end

  contador_bcd_3dig u_bcd (
    .clock  (clock),
    .reset  (reset),
    .clear  (bcd_clear_c),
    .enable (bcd_en_c),
    .count  (bcd_count)
  );

  // Measurement sequencer; the detecting echo cycle counts as the first high cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cycle_cnt <= '0;
      echo_cnt  <= '0;
      trigger   <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      medida    <= '0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (medir) state <= ST_PREPARA;
        end
        ST_PREPARA: begin
          cycle_cnt <= '0;
          echo_cnt  <= '0;
          trigger   <= 1'b1;
          state     <= ST_TRIGGER;
        end
        ST_TRIGGER: begin
          if (cycle_cnt == CNT_W'(TRIGGER_CYCLES - 1)) begin
            trigger   <= 1'b0;
            cycle_cnt <= '0;
            state     <= ST_ESPERA_ECHO;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_ESPERA_ECHO: begin
          if (echo_sync) begin
            echo_cnt  <= ECHO_W'(1);
            cycle_cnt <= (CM_CYCLES == 1) ? '0 : CNT_W'(1);
            state     <= ST_MEDE;
          end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            erro  <= 1'b1;
            state <= ST_ERRO;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        ST_MEDE: begin
          if (!echo_sync) begin
            state <= ST_ARMAZENA;
          end else if (echo_cnt == ECHO_W'(ECHO_MAX_CYCLES - 1)) begin
            erro  <= 1'b1;
            state <= ST_ERRO;
          end else begin
            echo_cnt  <= echo_cnt + ECHO_W'(1);
            cycle_cnt <= wrap_c ? '0 : cycle_cnt + CNT_W'(1);
          end
        end
        ST_ARMAZENA: begin
          medida <= bcd_count;
          pronto <= 1'b1;
          state  <= ST_FIM;
        end
        ST_FIM:  state <= ST_IDLE;
        ST_ERRO: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign db_estado = state;

endmodule
